// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - operand-read / writeback / issue bundle for regfile_sb
//
// Purpose: groups every pipeline-facing signal of the register file so that
// decode, writeback and the file itself share one typed connection.
//
// Signals:
//   rd_en, rsel0, rsel1       operand read request and the two register indices
//   read0, read1, rd_valid    registered operand data and its valid flag
//   stall                     combinational refusal of the current read request
//   we, wsel, w               writeback strobe, index and data
//   iss_en, iss_sel           issue strobe and destination index
//   busy                      one pending bit per register
//
// Modports: master = pipeline side, slave = register file side.

interface regfile_sb_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic             rd_en;
  logic [AW-1:0]    rsel0;
  logic [AW-1:0]    rsel1;
  logic [WIDTH-1:0] read0;
  logic [WIDTH-1:0] read1;
  logic             rd_valid;
  logic             stall;
  logic             we;
  logic [AW-1:0]    wsel;
  logic [WIDTH-1:0] w;
  logic             iss_en;
  logic [AW-1:0]    iss_sel;
  logic [DEPTH-1:0] busy;

  modport master (
    output rd_en, rsel0, rsel1, we, wsel, w, iss_en, iss_sel,
    input  read0, read1, rd_valid, stall, busy
  );

  modport slave (
    input  rd_en, rsel0, rsel1, we, wsel, w, iss_en, iss_sel,
    output read0, read1, rd_valid, stall, busy
  );
endinterface

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with dual registered read ports and pending-bit scoreboard
//
// Purpose: DEPTH x WIDTH register file for a five-stage pipeline. Decode reads
// two operands (1-cycle registered latency) and issues a destination, which
// marks it pending; writeback stores the result and clears the pending bit.
// Reads of pending registers raise stall instead of returning stale data.
//
// Ports:
//   sysclk   single clock, rising edge
//   rst      synchronous active-high reset (clears storage, scoreboard, outputs)
//   bus      regfile_sb_if.slave: read request/data, writeback, issue, busy
//
// Build option: REGFILE_BYPASS_EN forwards a same-cycle writeback to the read
// ports and suppresses that register's hazard. Undefined: reads see pre-write
// contents and a pending register stalls through its writeback cycle.

module regfile_sb #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input logic         sysclk,
  input logic         rst,
  regfile_sb_if.slave bus
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_next;
  logic [WIDTH-1:0] read0_q;
  logic [WIDTH-1:0] read1_q;
  logic             rd_valid_q;

  // Select range checks; only a non-power-of-two depth has unused indices.
  logic ok_rs0, ok_rs1, ok_w, ok_iss;

  generate
    if (DEPTH == (1 << AW)) begin : g_full
      assign ok_rs0 = 1'b1;
      assign ok_rs1 = 1'b1;
      assign ok_w   = 1'b1;
      assign ok_iss = 1'b1;
    end else begin : g_partial
      assign ok_rs0 = {{(32-AW){1'b0}}, bus.rsel0}   < 32'(DEPTH);
      assign ok_rs1 = {{(32-AW){1'b0}}, bus.rsel1}   < 32'(DEPTH);
      assign ok_w   = {{(32-AW){1'b0}}, bus.wsel}    < 32'(DEPTH);
      assign ok_iss = {{(32-AW){1'b0}}, bus.iss_sel} < 32'(DEPTH);
    end
  endgenerate

  logic [WIDTH-1:0] rd0_data, rd1_data;
  logic             busy_rs0, busy_rs1;

  // Out-of-range reads return zero and are never considered pending.
  assign rd0_data = ok_rs0 ? regs[bus.rsel0] : '0;
  assign rd1_data = ok_rs1 ? regs[bus.rsel1] : '0;
  assign busy_rs0 = ok_rs0 & busy_q[bus.rsel0];
  assign busy_rs1 = ok_rs1 & busy_q[bus.rsel1];

  logic [WIDTH-1:0] src0, src1;
  logic             hz0, hz1;

`ifdef REGFILE_BYPASS_EN
  logic fwd0, fwd1;
  assign fwd0 = bus.we & ok_w & (bus.wsel == bus.rsel0);
  assign fwd1 = bus.we & ok_w & (bus.wsel == bus.rsel1);
  assign src0 = fwd0 ? bus.w : rd0_data;
  assign src1 = fwd1 ? bus.w : rd1_data;
  // The writeback arriving this cycle resolves the hazard it would raise.
  assign hz0  = busy_rs0 & ~fwd0;
  assign hz1  = busy_rs1 & ~fwd1;
`else
  assign src0 = rd0_data;
  assign src1 = rd1_data;
  assign hz0  = busy_rs0;
  assign hz1  = busy_rs1;
`endif

  logic stall, accept;
  // Uses busy before this cycle's issue: a read of the issuing destination
  // precedes that instruction in program order.
  assign stall  = bus.rd_en & (hz0 | hz1);
  assign accept = bus.rd_en & ~stall;

  // Clear first, then set, so a same-index writeback and issue leaves it pending.
  always_comb begin
    busy_next = busy_q;
    if (bus.we && ok_w)
      busy_next[bus.wsel] = 1'b0;
    if (bus.iss_en && ok_iss)
      busy_next[bus.iss_sel] = 1'b1;
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
      busy_q     <= '0;
      read0_q    <= '0;
      read1_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (bus.we && ok_w)
        regs[bus.wsel] <= bus.w;
      busy_q <= busy_next;
      if (accept) begin
        read0_q <= src0;
        read1_q <= src1;
      end
      rd_valid_q <= accept;
    end
  end

  assign bus.read0    = read0_q;
  assign bus.read1    = read1_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.stall    = stall;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed self-checking bench for regfile_sb

module tb_regfile_sb;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  regfile_sb_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  regfile_sb #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .sysclk (clk),
    .rst    (rst),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and land 1 time unit after it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rd_en   = 1'b0;
    bus.we      = 1'b0;
    bus.iss_en  = 1'b0;
  endtask

  task automatic read_req(input logic [1:0] s0, input logic [1:0] s1);
    bus.rd_en = 1'b1;
    bus.rsel0 = s0;
    bus.rsel1 = s1;
  endtask

  task automatic wb(input logic [1:0] sel, input logic [7:0] data);
    bus.we   = 1'b1;
    bus.wsel = sel;
    bus.w    = data;
  endtask

  task automatic issue(input logic [1:0] sel);
    bus.iss_en  = 1'b1;
    bus.iss_sel = sel;
  endtask

  initial begin
    rst         = 1'b1;
    bus.rd_en   = 1'b0;
    bus.rsel0   = '0;
    bus.rsel1   = '0;
    bus.we      = 1'b0;
    bus.wsel    = '0;
    bus.w       = '0;
    bus.iss_en  = 1'b0;
    bus.iss_sel = '0;
    cycle();
    cycle();
    rst = 1'b0;

    check("rst_read0", 32'(bus.read0), 32'h0);
    check("rst_read1", 32'(bus.read1), 32'h0);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);

    // Read r0/r1 after reset.
    read_req(2'd0, 2'd1);
    #1 check("r01_stall", 32'(bus.stall), 32'h0);
    cycle();
    idle();
    check("r01_read0", 32'(bus.read0), 32'h0);
    check("r01_read1", 32'(bus.read1), 32'h0);
    check("r01_rd_valid", 32'(bus.rd_valid), 32'h1);
    check("r01_busy", 32'(bus.busy), 32'h0);
    #1 cycle();
    check("idle_rd_valid", 32'(bus.rd_valid), 32'h0);

    // Write 0xA5 to r2, read it the next cycle.
    wb(2'd2, 8'hA5);
    cycle();
    idle();
    read_req(2'd2, 2'd2);
    cycle();
    idle();
    check("wr_read0", 32'(bus.read0), 32'hA5);
    check("wr_read1_same_sel", 32'(bus.read1), 32'hA5);
    check("wr_rd_valid", 32'(bus.rd_valid), 32'h1);

    // Issue r3, then read it: stall and hold.
    issue(2'd3);
    cycle();
    idle();
    check("iss3_busy", 32'(bus.busy), 32'h8);
    read_req(2'd0, 2'd3);
    #1 check("hz_stall", 32'(bus.stall), 32'h1);
    cycle();
    check("hz_rd_valid", 32'(bus.rd_valid), 32'h0);
    check("hz_hold0", 32'(bus.read0), 32'hA5);
    check("hz_hold1", 32'(bus.read1), 32'hA5);
    // Writeback 0x3C to r3 while the read is still requested.
    wb(2'd3, 8'h3C);
`ifdef REGFILE_BYPASS_EN
    #1 check("wb_stall_bypass", 32'(bus.stall), 32'h0);
    cycle();
    idle();
    check("wb_rd_valid", 32'(bus.rd_valid), 32'h1);
    check("wb_read0", 32'(bus.read0), 32'h0);
    check("wb_read1_fwd", 32'(bus.read1), 32'h3C);
    check("wb_busy", 32'(bus.busy), 32'h0);
`else
    #1 check("wb_stall_nobypass", 32'(bus.stall), 32'h1);
    cycle();
    bus.we = 1'b0;
    check("wb_rd_valid_stalled", 32'(bus.rd_valid), 32'h0);
    check("wb_busy", 32'(bus.busy), 32'h0);
    #1 check("wb_stall_after", 32'(bus.stall), 32'h0);
    cycle();
    idle();
    check("wb_rd_valid", 32'(bus.rd_valid), 32'h1);
    check("wb_read0", 32'(bus.read0), 32'h0);
    check("wb_read1", 32'(bus.read1), 32'h3C);
`endif

    // Same-cycle writeback and issue to r1: set wins, data still written.
    wb(2'd1, 8'h11);
    issue(2'd1);
    cycle();
    idle();
    check("setwins_busy", 32'(bus.busy), 32'h2);
    read_req(2'd1, 2'd1);
    #1 check("setwins_stall", 32'(bus.stall), 32'h1);
    cycle();
    idle();
    wb(2'd1, 8'h11);
    cycle();
    idle();
    check("setwins_clear", 32'(bus.busy), 32'h0);
    read_req(2'd1, 2'd0);
    cycle();
    idle();
    check("setwins_read0", 32'(bus.read0), 32'h11);

    // Issue r2 and read r2 in the same cycle: no stall, old value.
    issue(2'd2);
    read_req(2'd2, 2'd0);
    #1 check("iss_rd_stall", 32'(bus.stall), 32'h0);
    cycle();
    idle();
    check("iss_rd_valid", 32'(bus.rd_valid), 32'h1);
    check("iss_rd_read0", 32'(bus.read0), 32'hA5);
    check("iss_rd_busy", 32'(bus.busy), 32'h4);

    // Reset while r1 is busy and a read is pending; reset beats a writeback.
    issue(2'd1);
    cycle();
    idle();
    read_req(2'd1, 2'd3);
    #1 check("pre_rst_stall", 32'(bus.stall), 32'h1);
    rst = 1'b1;
    wb(2'd0, 8'hFF);
    cycle();
    rst = 1'b0;
    idle();
    check("mid_rst_read0", 32'(bus.read0), 32'h0);
    check("mid_rst_read1", 32'(bus.read1), 32'h0);
    check("mid_rst_rd_valid", 32'(bus.rd_valid), 32'h0);
    check("mid_rst_busy", 32'(bus.busy), 32'h0);
    read_req(2'd2, 2'd3);
    #1 check("post_rst_stall", 32'(bus.stall), 32'h0);
    cycle();
    read_req(2'd0, 2'd1);
    check("post_rst_r2", 32'(bus.read0), 32'h0);
    check("post_rst_r3", 32'(bus.read1), 32'h0);
    check("post_rst_rd_valid", 32'(bus.rd_valid), 32'h1);
    cycle();
    idle();
    check("post_rst_r0", 32'(bus.read0), 32'h0);
    check("post_rst_r1", 32'(bus.read1), 32'h0);

    // Writeback to a formerly busy register is a plain write.
    wb(2'd1, 8'h5A);
    cycle();
    idle();
    check("plain_wb_busy", 32'(bus.busy), 32'h0);
    read_req(2'd3, 2'd1);
    cycle();
    idle();
    check("plain_wb_read1", 32'(bus.read1), 32'h5A);
    check("plain_wb_read0", 32'(bus.read0), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
